// File: rtl/alu_responder.sv
// Handshaked ALU responder: computes add/sub/not/and/or/xor on accept and
// returns tagged results in order through a 2-entry response FIFO.
module alu_responder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_carry,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [3:0]            rsp_tag
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  carry;
      logic                  zero;
      logic                  err;
      logic [3:0]            tag;
   } entry_t;

   // Full response entry for one request; illegal opcodes yield result 0 with err set.
   function automatic entry_t alu_eval(
      input logic [2:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [3:0]            tag
   );
      entry_t              e;
      logic [DATA_WIDTH:0] sum;
      e     = '0;
      e.tag = tag;
      sum   = {1'b0, a} + {1'b0, b};
      case (op)
         OP_ADD: begin
            e.result = sum[DATA_WIDTH-1:0];
            e.carry  = sum[DATA_WIDTH];
         end
         OP_SUB: begin
            e.result = a - b;
            e.carry  = (a < b);
         end
         OP_NOT:  e.result = ~a;
         OP_AND:  e.result = a & b;
         OP_OR:   e.result = a | b;
         OP_XOR:  e.result = a ^ b;
         default: begin
            e.result = '0;
            e.err    = 1'b1;
         end
      endcase
      e.zero = (e.result == '0);
      return e;
   endfunction

   entry_t     mem_q [2];
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;
   logic [3:0] tag_q, tag_d;
   logic       accept;
   logic       retire;
   entry_t     new_entry;
   entry_t     head;

   // Handshake readiness comes only from registered count, never from rsp_ready.
   assign req_ready = (count_q != 2'd2);
   assign rsp_valid = (count_q != 2'd0);

   assign head       = mem_q[rd_ptr_q];
   assign rsp_result = head.result;
   assign rsp_carry  = head.carry;
   assign rsp_zero   = head.zero;
   assign rsp_err    = head.err;
   assign rsp_tag    = head.tag;

   // Next-state for pointers, occupancy and tag.
   always_comb begin
      accept    = req_valid && req_ready;
      retire    = rsp_valid && rsp_ready;
      new_entry = alu_eval(req_op, req_a, req_b, tag_q);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      tag_d     = tag_q;
      count_d   = count_q;
      if (accept) begin
         wr_ptr_d = ~wr_ptr_q;
         tag_d    = tag_q + 4'd1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (retire) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({accept, retire})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset drops buffered responses and any same-cycle accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         tag_q    <= 4'd0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= new_entry;
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         tag_q    <= tag_d;
      end
   end

endmodule

// File: tb/tb_alu_responder.sv
// Randomized self-checking bench for alu_responder against a queue-based
// reference model of the response stream.
module tb_alu_responder;

   typedef struct packed {
      logic [31:0] result;
      logic        carry;
      logic        zero;
      logic        err;
      logic [3:0]  tag;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_err;
   logic [3:0]  rsp_tag;

   int   n_cmp = 0;
   int   n_err = 0;
   rsp_t exp_q[$];
   int   tag_m = 0;

   alu_responder #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
   );

   always #5 clk = ~clk;

   function automatic rsp_t ref_calc(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input int tag);
      rsp_t   r;
      longint s;
      r = '0;
      r.tag = tag[3:0];
      case (op)
         3'd0: begin
            s = longint'(a) + longint'(b);
            r.result = s[31:0];
            r.carry = (s > 64'sd4294967295);
         end
         3'd1: begin
            s = longint'(a) - longint'(b);
            r.result = s[31:0];
            r.carry = (s < 64'sd0);
         end
         3'd2: r.result = ~a;
         3'd3: r.result = a & b;
         3'd4: r.result = a | b;
         3'd5: r.result = a ^ b;
         default: r.err = 1'b1;
      endcase
      r.zero = (r.result == 32'd0);
      return r;
   endfunction

   function automatic rsp_t obs();
      return {rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag};
   endfunction

   // Advance the model with the inputs present at this edge, then step the clock.
   task automatic tick();
      bit acc, ret;
      acc = req_valid && (exp_q.size() < 2);
      ret = rsp_ready && (exp_q.size() != 0);
      if (reset) begin
         exp_q.delete();
         tag_m = 0;
      end else begin
         if (ret) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(ref_calc(req_op, req_a, req_b, tag_m));
            tag_m = (tag_m + 1) % 16;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      n_cmp++; if (obs() !== rsp_t'(0)) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs()); end
   endtask

   task automatic test_add();
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'hFFFF_FFFF; req_b = 32'd1; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
      n_cmp++; if (obs() !== {32'h0, 1'b1, 1'b1, 1'b0, 4'd0}) begin n_err++; $display("FAIL add_fields: got %h want %h", obs(), {32'h0, 1'b1, 1'b1, 1'b0, 4'd0}); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_back_to_back_sub();
      int t0;
      t0 = tag_m;
      req_valid = 1'b1; req_op = 3'd1; req_a = 32'd3; req_b = 32'd5; rsp_ready = 1'b1;
      tick();
      n_cmp++; if (obs() !== {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'(t0)}) begin n_err++; $display("FAIL sub_borrow: got %h want %h", obs(), {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'(t0)}); end
      req_a = 32'd5; req_b = 32'd3;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sub_b2b_valid: got %b want 1", rsp_valid); end
      n_cmp++; if (obs() !== {32'd2, 1'b0, 1'b0, 1'b0, 4'((t0 + 1) % 16)}) begin n_err++; $display("FAIL sub_noborrow: got %h want %h", obs(), {32'd2, 1'b0, 1'b0, 1'b0, 4'((t0 + 1) % 16)}); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_back_pressure();
      rsp_ready = 1'b0; req_valid = 1'b1; req_a = 32'hF0F0_F0F0; req_b = 32'hFF00_FF00;
      req_op = 3'd3;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready0: got %b want 1", req_ready); end
      tick();
      req_op = 3'd4;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", req_ready); end
      tick();
      req_op = 3'd5;
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b want 0", req_ready); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (rsp_result !== 32'hF000_F000 || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d: got %h/%b/%b want f000f000/1/0", i, rsp_result, rsp_valid, req_ready); end
      end
      rsp_ready = 1'b1;
      tick();
      n_cmp++; if (rsp_result !== 32'hFFF0_FFF0 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_drain1: got %h/%b want fff0fff0/1", rsp_result, req_ready); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_result !== 32'h0FF0_0FF0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain2: got %h/%b want 0ff00ff0/1", rsp_result, rsp_valid); end
      n_cmp++; if (exp_q.size() == 0 || obs() !== exp_q[0]) begin n_err++; $display("FAIL bp_model: got %h want %h", obs(), (exp_q.size() != 0) ? exp_q[0] : rsp_t'(0)); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
   endtask

   task automatic test_illegal();
      int t0;
      for (int op = 6; op < 8; op++) begin
         t0 = tag_m;
         req_valid = 1'b1; req_op = 3'(op); req_a = $urandom; req_b = $urandom; rsp_ready = 1'b1;
         tick();
         req_valid = 1'b0;
         n_cmp++; if (obs() !== {32'h0, 1'b0, 1'b1, 1'b1, 4'(t0)}) begin n_err++; $display("FAIL illegal_op%0d: got %h want %h", op, obs(), {32'h0, 1'b0, 1'b1, 1'b1, 4'(t0)}); end
         tick();
      end
   endtask

   task automatic test_stream();
      reset = 1'b1; tick(); reset = 1'b0;
      rsp_ready = 1'b1; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req_op = 3'($urandom_range(0, 7));
         req_a  = (i % 7 == 3) ? 32'hFFFF_FFFF : $urandom;
         req_b  = (i % 5 == 0) ? req_a : $urandom;
         tick();
         n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin n_err++; $display("FAIL stream_hs%0d: got %b/%b want 1/1", i, rsp_valid, req_ready); end
         n_cmp++; if (rsp_tag !== 4'(i % 16)) begin n_err++; $display("FAIL stream_tag%0d: got %0d want %0d", i, rsp_tag, i % 16); end
         n_cmp++; if (exp_q.size() == 0 || obs() !== exp_q[0]) begin n_err++; $display("FAIL stream_data%0d: got %h want %h", i, obs(), (exp_q.size() != 0) ? exp_q[0] : rsp_t'(0)); end
      end
      req_valid = 1'b0;
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_reset_full();
      logic [31:0] a0;
      rsp_ready = 1'b0; req_valid = 1'b1; req_op = 3'd0;
      req_a = $urandom; req_b = $urandom; tick();
      req_a = $urandom; req_b = $urandom; tick();
      n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL rstfull_pre: got %b/%b want 0/1", req_ready, rsp_valid); end
      reset = 1'b1; rsp_ready = 1'b1;
      tick();
      reset = 1'b0; req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rstfull_post: got %b/%b want 0/1", rsp_valid, req_ready); end
      a0 = $urandom;
      req_valid = 1'b1; req_op = 3'd2; req_a = a0;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_result !== ~a0) begin n_err++; $display("FAIL rstfull_first: got %b/%0d/%h want 1/0/%h", rsp_valid, rsp_tag, rsp_result, ~a0); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add();
      test_back_to_back_sub();
      test_back_pressure();
      test_illegal();
      test_stream();
      test_reset_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_responder.md
# alu_responder

Handshaked, registered responder front-end for the combinational ALU operation set (add, sub, not, and, or, xor). An upstream initiator issues opcode/operand requests over a valid/ready channel. The block computes the result with carry/zero/error flags and returns it in order over a second valid/ready channel, buffering up to two responses. It sits between a command sequencer and any consumer that may stall.

## Interface
- DATA_WIDTH, 32, operand and result width (>= 2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  3  opcode: 0 add, 1 sub, 2 not_a, 3 and, 4 or, 5 xor, 6-7 illegal
- req_a  in  DATA_WIDTH  operand A
- req_b  in  DATA_WIDTH  operand B
- rsp_valid  out  1  response present at buffer head
- rsp_ready  in  1  consumer takes the head response
- rsp_result  out  DATA_WIDTH  head result
- rsp_carry  out  1  add: carry-out; sub: borrow (a < b unsigned); else 0
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  illegal opcode
- rsp_tag  out  4  sequence number of the request that produced this response

## Operation
- Request accepted on a cycle where req_valid && req_ready; response returned on a cycle where rsp_valid && rsp_ready.
- Compute on accept: add = (a+b) mod 2^W, carry = bit W of the (W+1)-bit sum; sub = (a-b) mod 2^W, carry = 1 iff a < b unsigned; not/and/or/xor bitwise, carry 0.
- Illegal opcode (6, 7): result 0, carry 0, err 1, zero 1. It is still accepted and consumes a buffer slot and a tag.
- Response buffer: 2-entry FIFO (entry = result, carry, zero, err, tag) with read pointer, write pointer and 2-bit count (0..2).
- Tag counter: 4 bits, 0 after reset, increments by 1 per accepted request, wraps 15 -> 0. Each response carries the tag value present at its acceptance.
- req_ready = (count < 2), taken from registered count only. No combinational path from rsp_ready to req_ready.
- rsp_valid = (count != 0). rsp_* outputs are driven from the head entry and held stable while rsp_valid && !rsp_ready.
- Responses are returned strictly in acceptance order.
- Simultaneous accept and return at count 1: count stays 1; the new entry becomes head next cycle.
- At count 2 with rsp_ready=1: a return occurs, no accept that cycle, and count becomes 1.
- req_* inputs are ignored when req_valid=0 or req_ready=0.

## Timing
- Latency: request accepted at edge k → response visible (rsp_valid=1) after edge k, i.e. the cycle following acceptance. Minimum 1 cycle.
- Sustained throughput: 1 request/cycle when the consumer holds rsp_ready=1.
- Reset values on the cycle after reset is sampled high: rsp_valid 0, req_ready 1, count 0, pointers 0, tag 0, rsp_result 0, rsp_carry 0, rsp_zero 0, rsp_err 0.
- Reset mid-operation: all buffered responses are discarded with no partial return, and an accept in the reset cycle is dropped. Reset has priority over all handshakes.
- Buffer entries that are not the head are don't-care on the outputs.

## Test plan
- Reset then single add, W=32: a=0xFFFFFFFF, b=1, rsp_ready=1 → next cycle rsp_valid=1, result 0, carry 1, zero 1, err 0, tag 0.
- Sub borrow: a=3, b=5 → result 0xFFFFFFFE, carry 1, zero 0. Then a=5, b=3 → result 2, carry 0, tag 1.
- Back-pressure: rsp_ready=0 with 3 consecutive valid requests (and, or, xor on a=0xF0F0F0F0, b=0xFF00FF00) → first two accepted, req_ready=0 on cycle 3. Outputs hold 0xF000F000 stable. Raising rsp_ready drains 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0 in order, and the third request is accepted after count drops.
- Illegal opcode 7 → result 0, err 1, zero 1, carry 0. Tag advances.
- Streaming 20 random ops with rsp_ready=1 throughout → one response per cycle with 1-cycle latency. Tags run 0..15, 0..3 (wrap checked). Every result matches the reference model.
- Reset asserted with count=2 → next cycle rsp_valid=0, req_ready=1. The next accepted request returns tag 0.
